matrix_processor_controller: RTL and testbench

MATRIX_PROCESSOR_CONTROLLER -- requirements
Module: matrix_processor_controller

---
 rtl/mp_ctrl_pkg.sv | 24 ++
 rtl/matrix_processor_controller.sv | 127 ++++++++++++
 tb/tb_matrix_processor_controller.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mp_ctrl_pkg.sv
// Shared types and geometry constants for the matrix-vector processor controller.
package mp_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    LD_MTX,
    LD_VEC,
    SETTLE,
    MAC,
    FLUSH,
    WB,
    NEXT_WI,
    DONE
  } state_t;

  localparam int MAT_ELEMS = 16;
  localparam int VEC_ELEMS = 4;
  localparam int ROW_LEN   = 4;

  localparam logic [3:0] MAT_LAST = 4'(MAT_ELEMS - 1);
  localparam logic [3:0] VEC_LAST = 4'(VEC_ELEMS - 1);

endpackage

// File: rtl/matrix_processor_controller.sv
// Sequencer for a 4x4 matrix times vector job stream (FMA_LAT must be >= 1).
// Optional busy-cycle counter on perf_cycles when MPC_PERF_CNT_EN is defined.
module matrix_processor_controller
  import mp_ctrl_pkg::*;
#(
  parameter int FMA_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  input  logic        workItemCountZero,
  input  logic [3:0]  matrixRegValue,
  output logic        rd_req,
  input  logic        rd_gnt,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic        wiSource,
  output logic        wiInit,
  output logic        resetMatrixReg,
  output logic        matrixRegIncrument,
  output logic        load,
  output logic        loadMatrix,
  output logic        loadVector,
  output logic        readAddrSrc,
  output logic        enFMA
`ifdef MPC_PERF_CNT_EN
  ,
  output logic [31:0] perf_cycles
`endif
);

  localparam int                FL_W       = $clog2(FMA_LAT + 1);
  localparam logic [FL_W-1:0]   FLUSH_LAST = FL_W'(FMA_LAT - 1);
  localparam int                MC_W       = $clog2(ROW_LEN);
  localparam logic [MC_W-1:0]   MAC_LAST   = MC_W'(ROW_LEN - 1);

  state_t            state, nextState;
  logic [MC_W-1:0]   macCnt, macCntNext;
  logic [FL_W-1:0]   flushCnt, flushCntNext;
  logic              macIncr;

  always_comb begin
    nextState    = state;
    macCntNext   = '0;
    flushCntNext = '0;
    unique case (state)
      IDLE:    if (start && !abort) nextState = INIT;
      INIT:    nextState = LD_MTX;
      LD_MTX:  if (rd_gnt && matrixRegValue == MAT_LAST) nextState = LD_VEC;
      LD_VEC:  if (rd_gnt && matrixRegValue == VEC_LAST) nextState = SETTLE;
      SETTLE:  nextState = MAC;
      MAC: begin
        if (macCnt == MAC_LAST) nextState = FLUSH;
        else                    macCntNext = macCnt + 1'b1;
      end
      FLUSH: begin
        if (flushCnt == FLUSH_LAST) nextState = WB;
        else                        flushCntNext = flushCnt + 1'b1;
      end
      WB:      if (wr_ready) nextState = (matrixRegValue == MAT_LAST) ? NEXT_WI : MAC;
      NEXT_WI: nextState = workItemCountZero ? DONE : LD_VEC;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (abort && state != IDLE) nextState = IDLE;
  end

  // NOTE: reset is sampled on the clock edge, so it lives inside the clocked
  // branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      macCnt      <= '0;
      flushCnt    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_req      <= 1'b0;
      readAddrSrc <= 1'b0;
      wr_valid    <= 1'b0;
      wiInit      <= 1'b0;
      enFMA       <= 1'b0;
      macIncr     <= 1'b0;
    end else begin
      state       <= nextState;
      macCnt      <= macCntNext;
      flushCnt    <= flushCntNext;
      busy        <= (nextState != IDLE);
      done        <= (nextState == DONE);
      rd_req      <= (nextState == LD_MTX) || (nextState == LD_VEC);
      readAddrSrc <= (nextState == LD_VEC);
      wr_valid    <= (nextState == WB);
      wiInit      <= (nextState == INIT);
      enFMA       <= (nextState == MAC);
      macIncr     <= (nextState == MAC) && (macCntNext != MAC_LAST);
    end
  end

  // NOTE: strobes tied to a grant, a write acceptance or the work-item flag must
  // react in the same cycle, so they are decoded from the registered state and
  // the live input instead of being registered.
  logic mtxGnt, vecGnt, vecLastGnt, wbAccept, moreItems;

  assign mtxGnt     = (state == LD_MTX) && rd_gnt;
  assign vecGnt     = (state == LD_VEC) && rd_gnt;
  assign vecLastGnt = vecGnt && (matrixRegValue == VEC_LAST);
  assign wbAccept   = (state == WB) && wr_ready;
  assign moreItems  = (state == NEXT_WI) && !workItemCountZero;

  assign load               = mtxGnt || vecGnt;
  assign loadMatrix         = mtxGnt;
  assign loadVector         = vecGnt;
  assign matrixRegIncrument = macIncr || mtxGnt || (vecGnt && !vecLastGnt) || wbAccept;
  assign resetMatrixReg     = wiInit || vecLastGnt || moreItems;
  assign wiSource           = wiInit || moreItems;

`ifdef MPC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                                 perf_cycles <= '0;
    else if (state == IDLE && start && !abort)  perf_cycles <= '0;
    else if (busy && perf_cycles != '1)         perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_matrix_processor_controller.sv
// Directed bench: models the datapath counters and memory handshakes around the controller.
module tb_matrix_processor_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic rd_gnt = 1'b1;
  logic wr_ready = 1'b0;
  logic workItemCountZero;
  logic [3:0] matrixRegValue;
  logic busy, done, rd_req, wr_valid;
  logic wiSource, wiInit, resetMatrixReg, matrixRegIncrument;
  logic load, loadMatrix, loadVector, readAddrSrc, enFMA;
`ifdef MPC_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  always #5 clk = ~clk;

  matrix_processor_controller #(.FMA_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done),
    .workItemCountZero(workItemCountZero), .matrixRegValue(matrixRegValue),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wiSource(wiSource), .wiInit(wiInit), .resetMatrixReg(resetMatrixReg),
    .matrixRegIncrument(matrixRegIncrument), .load(load), .loadMatrix(loadMatrix),
    .loadVector(loadVector), .readAddrSrc(readAddrSrc), .enFMA(enFMA)
`ifdef MPC_PERF_CNT_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  // Environment knobs, written only by the stimulus block.
  int jobItems = 0;
  bit gntRandom = 1'b0;
  int wrStall = 0;
  bit clrReq = 1'b0;

  // Datapath model: element counter and work-item down-counter.
  logic [3:0] mrv = '0;
  int wiCnt = 0;
  assign matrixRegValue    = mrv;
  assign workItemCountZero = (wiCnt == 0);

  // Event counters, cleared on request.
  int nLdMat, nLdVec, nFma, nWr, nDone, nWiSrc, nGnt, nLoad, nLoadNoGnt, nDrop, nBusy, wrSum;
  logic wrValidQ = 1'b0, wrReadyQ = 1'b0, abortQ = 1'b0;

  always @(posedge clk) begin
    if (!rst_n || resetMatrixReg) mrv <= '0;
    else if (matrixRegIncrument)  mrv <= mrv + 4'd1;
    if (wiInit)        wiCnt <= jobItems;
    else if (wiSource) wiCnt <= wiCnt - 1;

    wrValidQ <= wr_valid;
    wrReadyQ <= wr_ready;
    abortQ   <= abort || !rst_n;

    if (clrReq) begin
      nLdMat <= 0; nLdVec <= 0; nFma <= 0; nWr <= 0; nDone <= 0; nWiSrc <= 0;
      nGnt <= 0; nLoad <= 0; nLoadNoGnt <= 0; nDrop <= 0; nBusy <= 0; wrSum <= 0;
    end else begin
      if (loadMatrix)        nLdMat <= nLdMat + 1;
      if (loadVector)        nLdVec <= nLdVec + 1;
      if (enFMA)             nFma <= nFma + 1;
      if (done)              nDone <= nDone + 1;
      if (wiSource)          nWiSrc <= nWiSrc + 1;
      if (rd_req && rd_gnt)  nGnt <= nGnt + 1;
      if (load)              nLoad <= nLoad + 1;
      if (load && !rd_gnt)   nLoadNoGnt <= nLoadNoGnt + 1;
      if (busy)              nBusy <= nBusy + 1;
      if (wr_valid && wr_ready) begin
        nWr   <= nWr + 1;
        wrSum <= wrSum + int'(mrv);
      end
      if (wrValidQ && !wrReadyQ && !wr_valid && !abortQ) nDrop <= nDrop + 1;
    end
  end

  // Memory-side responder: grants and write-ready, changed on the falling edge.
  int wrWait = 0;
  always @(negedge clk) begin
    rd_gnt = gntRandom ? 1'($urandom_range(0, 1)) : 1'b1;
    if (wr_valid) wrWait = wrWait + 1;
    else          wrWait = 0;
    wr_ready = (wrWait > wrStall);
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counters();
    @(negedge clk) clrReq = 1'b1;
    @(negedge clk) clrReq = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_finished"}, seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_req", rd_req, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_strobes", {wiSource, wiInit, resetMatrixReg, matrixRegIncrument, load,
                          loadMatrix, loadVector, readAddrSrc, enFMA}, 0);
    rst_n = 1'b1;

    // Single work item, everything granted immediately.
    jobItems = 0; gntRandom = 1'b0; wrStall = 0;
    clear_counters();
    pulse_start();
    check("a_init_busy", busy, 1);
    check("a_init_wiInit", {wiInit, wiSource, resetMatrixReg}, 3'b111);
    wait_idle("a", 500);
    check("a_ldmat", nLdMat, 16);
    check("a_ldvec", nLdVec, 4);
    check("a_fma", nFma, 16);
    check("a_writes", nWr, 4);
    check("a_done", nDone, 1);
    check("a_busy_cycles", nBusy, 52);
    check("a_wr_rows", wrSum, 36);
    check("a_rd_req_end", rd_req, 0);

    // Three work items share one cached matrix.
    jobItems = 2;
    clear_counters();
    pulse_start();
    wait_idle("b", 1000);
    check("b_ldmat", nLdMat, 16);
    check("b_ldvec", nLdVec, 12);
    check("b_fma", nFma, 48);
    check("b_writes", nWr, 12);
    check("b_wisource", nWiSrc, 3);
    check("b_done", nDone, 1);
    check("b_busy_cycles", nBusy, 120);
    check("b_wr_rows", wrSum, 108);

    // Random read grants and stalled writes.
    jobItems = 1; gntRandom = 1'b1; wrStall = 5;
    clear_counters();
    pulse_start();
    wait_idle("c", 3000);
    gntRandom = 1'b0;
    check("c_ldmat", nLdMat, 16);
    check("c_ldvec", nLdVec, 8);
    check("c_load_vs_grant", nLoad, nGnt);
    check("c_load_no_grant", nLoadNoGnt, 0);
    check("c_writes", nWr, 8);
    check("c_wr_valid_drop", nDrop, 0);
    check("c_wr_rows", wrSum, 72);
    check("c_done", nDone, 1);

    // Abort while the third write of item 0 is pending.
    jobItems = 0; wrStall = 5;
    clear_counters();
    pulse_start();
    begin
      bit reached = 1'b0;
      for (int i = 0; i < 500; i++) begin
        @(negedge clk);
        if (nWr == 2 && wr_valid) begin
          reached = 1'b1;
          break;
        end
      end
      check("d_reached_wb3", reached, 1);
    end
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    check("d_abort_busy", busy, 0);
    check("d_abort_rd_req", rd_req, 0);
    check("d_abort_wr_valid", wr_valid, 0);
    repeat (5) @(negedge clk);
    check("d_abort_no_done", nDone, 0);
    check("d_abort_writes", nWr, 2);

    // Start together with abort in IDLE stays idle.
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    check("d_start_abort_idle", busy, 0);

    // Fresh job after the abort runs to completion.
    wrStall = 0;
    clear_counters();
    pulse_start();
    wait_idle("d2", 500);
    check("d2_done", nDone, 1);
    check("d2_writes", nWr, 4);

    // Second start while busy is ignored.
    clear_counters();
    pulse_start();
    repeat (8) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_idle("e", 500);
    check("e_done", nDone, 1);
    check("e_busy_cycles", nBusy, 52);
`ifdef MPC_PERF_CNT_EN
    check("e_perf", perf_cycles, 52);
    repeat (5) @(negedge clk);
    check("e_perf_hold", perf_cycles, 52);
`endif
    repeat (3) @(negedge clk);
    check("e_still_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
